tinyml_hw_accel_frame_ctrl: RTL and testbench

Frame-level sequencer for the camera-to-accelerator pixel pipeline (nearest-neighbour downscale followed by the RGB pack stage).
- On a CPU start request it holds the datapath in reset, then arms on the next camera start-of-frame.
- It gates exactly one input frame's pixel-valid strobes into the datapath and counts the packed output words.
- It reports done or error with a per-frame status.
- Pixel data does not pass through this block; only valid strobes and control do.

---
 rtl/tinyml_hw_accel_pkg.sv | 36 +++
 rtl/tinyml_hw_accel_frame_cnt.sv | 41 ++++
 rtl/tinyml_hw_accel_frame_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_tinyml_hw_accel_frame_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyml_hw_accel_pkg.sv
// Shared types and frame-geometry helpers for the camera-to-accelerator frame sequencer.
package tinyml_hw_accel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  function automatic int unsigned in_pixels(input int unsigned in_w, input int unsigned in_h);
    return in_w * in_h;
  endfunction

  function automatic int unsigned out_bytes(input int unsigned out_w, input int unsigned out_h,
                                            input int unsigned bpp);
    return out_w * out_h * bpp;
  endfunction

  // Packed output is 32-bit words, so the byte total must split evenly into words.
  function automatic int unsigned out_words(input int unsigned out_w, input int unsigned out_h,
                                            input int unsigned bpp);
    return out_bytes(out_w, out_h, bpp) / 4;
  endfunction

  // The clear phase shares the flush timer, so it must fit inside the timeout range.
  function automatic bit frame_cfg_ok(input int unsigned out_w, input int unsigned out_h,
                                      input int unsigned bpp, input int unsigned rst_cycles,
                                      input int unsigned flush_timeout);
    return ((out_bytes(out_w, out_h, bpp) % 4) == 0) && (rst_cycles >= 1) &&
           (rst_cycles <= flush_timeout);
  endfunction

endpackage

// File: rtl/tinyml_hw_accel_frame_cnt.sv
// Saturating, clearable event counter with terminal and one-before-terminal decodes.
module tinyml_hw_accel_frame_cnt #(
  parameter int unsigned W   = 20,
  parameter int unsigned MAX = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_c,
  output logic         pre_c
);

  localparam logic [W-1:0] MAX_V = W'(MAX);
  localparam logic [W-1:0] PRE_V = W'(MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_c  = (cnt_q == MAX_V);
  assign pre_c = (cnt_q == PRE_V);

endmodule

// File: rtl/tinyml_hw_accel_frame_ctrl.sv
// Frame sequencer: resets the pixel datapath, gates one camera frame of valid strobes
// into it, counts packed output words and reports done/error per frame.
module tinyml_hw_accel_frame_ctrl
  import tinyml_hw_accel_pkg::*;
#(
  parameter int unsigned IN_W          = 540,
  parameter int unsigned IN_H          = 540,
  parameter int unsigned OUT_W         = 192,
  parameter int unsigned OUT_H         = 192,
  parameter int unsigned BPP           = 3,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned FLUSH_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cam_sof,
  input  logic             cam_pixel_valid,
  output logic             accel_pixel_valid,
  output logic             accel_rst,
  input  logic             accel_out_valid,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] in_pixel_cnt,
  output logic [CNT_W-1:0] out_word_cnt
);

  localparam int unsigned      IN_PIXELS = in_pixels(IN_W, IN_H);
  localparam int unsigned      OUT_WORDS = out_words(OUT_W, OUT_H, BPP);
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);

  if (!frame_cfg_ok(OUT_W, OUT_H, BPP, RST_CYCLES, FLUSH_TIMEOUT)) begin : g_cfg_bad
    $error("frame_ctrl: OUT_W*OUT_H*BPP must be a multiple of 4 and 1 <= RST_CYCLES <= FLUSH_TIMEOUT");
  end

  state_e state_q, state_d;
  logic   accel_rst_q, busy_q, done_q, error_q, error_d;

  logic             fwd_c, cnt_clr, pix_inc, word_inc, tmr_clr, tmr_inc, err_set, words_full;
  logic             pix_tc, pix_pre, word_tc, word_pre, tmr_tc, tmr_pre;
  logic [CNT_W-1:0] tmr_cnt;

  tinyml_hw_accel_frame_cnt #(.W(CNT_W), .MAX(IN_PIXELS)) u_pix_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (pix_inc),
    .cnt_o (in_pixel_cnt),
    .tc_c  (pix_tc),
    .pre_c (pix_pre)
  );

  tinyml_hw_accel_frame_cnt #(.W(CNT_W), .MAX(OUT_WORDS)) u_word_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (word_inc),
    .cnt_o (out_word_cnt),
    .tc_c  (word_tc),
    .pre_c (word_pre)
  );

  // Shared cycle timer: times the CLEAR hold, then the idle gap between words in FLUSH.
  tinyml_hw_accel_frame_cnt #(.W(CNT_W), .MAX(FLUSH_TIMEOUT)) u_tmr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (tmr_clr),
    .inc_i (tmr_inc),
    .cnt_o (tmr_cnt),
    .tc_c  (tmr_tc),
    .pre_c (tmr_pre)
  );

  always_comb begin
    state_d    = state_q;
    fwd_c      = 1'b0;
    cnt_clr    = 1'b0;
    pix_inc    = 1'b0;
    tmr_clr    = 1'b0;
    tmr_inc    = 1'b0;
    err_set    = 1'b0;
    word_inc   = accel_out_valid && (state_q inside {ST_ARM, ST_RUN, ST_FLUSH});
    words_full = word_tc || (word_inc && word_pre);

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_CLEAR;
          cnt_clr = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (tmr_cnt == RST_LAST) begin
          state_d = ST_ARM;
          tmr_clr = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      ST_ARM: begin
        if (cam_pixel_valid && cam_sof) begin
          fwd_c   = 1'b1;
          pix_inc = 1'b1;
          state_d = pix_pre ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (cam_pixel_valid) begin
          if (cam_sof && !pix_tc) begin
            err_set = 1'b1;
            state_d = ST_DONE;
          end else begin
            fwd_c   = 1'b1;
            pix_inc = 1'b1;
            if (pix_pre) state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        tmr_clr = accel_out_valid;
        tmr_inc = !accel_out_valid;
        if (words_full) begin
          state_d = ST_DONE;
        end else if (tmr_tc || (tmr_pre && !accel_out_valid)) begin
          err_set = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (word_inc && word_tc) err_set = 1'b1;

    // Abort freezes status and counters; the forwarded strobe is left as-is since the
    // datapath is about to be reset anyway.
    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      pix_inc  = 1'b0;
      word_inc = 1'b0;
      tmr_clr  = 1'b0;
      tmr_inc  = 1'b0;
      err_set  = 1'b0;
      cnt_clr  = 1'b0;
    end

    error_d = error_q;
    if (cnt_clr) begin
      error_d = 1'b0;
    end else if (err_set) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      accel_rst_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      accel_rst_q <= (state_d inside {ST_IDLE, ST_CLEAR, ST_DONE});
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      error_q     <= error_d;
    end
  end

  assign accel_pixel_valid = fwd_c;
  assign accel_rst         = accel_rst_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;

endmodule

// File: tb/tb_tinyml_hw_accel_frame_ctrl.sv
// Randomized self-checking bench for the frame sequencer using a small 8x8 -> 4x4 RGB frame.
module tb_tinyml_hw_accel_frame_ctrl;

  localparam int unsigned CNT_W = 20;
  localparam int          RST_C = 4;
  localparam int          TMO   = 16;
  localparam int          NPIX  = 64;
  localparam int          NWORD = 12;
  localparam int          N     = 256;

  logic             clk, rst_n, start, abort, cam_sof, cam_pixel_valid, accel_out_valid;
  logic             accel_pixel_valid, accel_rst, busy, done, error;
  logic [CNT_W-1:0] in_pixel_cnt, out_word_cnt;

  int tests = 0;
  int fails = 0;

  tinyml_hw_accel_frame_ctrl #(
    .IN_W(8), .IN_H(8), .OUT_W(4), .OUT_H(4), .BPP(3),
    .RST_CYCLES(RST_C), .FLUSH_TIMEOUT(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .abort             (abort),
    .cam_sof           (cam_sof),
    .cam_pixel_valid   (cam_pixel_valid),
    .accel_pixel_valid (accel_pixel_valid),
    .accel_rst         (accel_rst),
    .accel_out_valid   (accel_out_valid),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .in_pixel_cnt      (in_pixel_cnt),
    .out_word_cnt      (out_word_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; abort = 0; cam_sof = 0; cam_pixel_valid = 0; accel_out_valid = 0;
  endtask

  // Builds a random frame schedule, predicts every strobe and the completion cycle from the
  // frame rules, drives it, and returns the expected final status.
  task automatic drive_frame(input string name, input int junk, input int n_pix,
                             input bit short_frame, input int n_words, input int gap_max,
                             output bit exp_err, output int exp_in, output int exp_out);
    bit pv[N]; bit sf[N]; bit wv[N]; bit ef[N];
    int i, sof_i, p, short_i, t, cnt, wc, w_full, wl, stop, done_iter, pulses, rst_len;
    bit first, tmo;
    for (int k = 0; k < N; k++) begin pv[k] = 0; sf[k] = 0; wv[k] = 0; ef[k] = 0; end
    i = int'($urandom_range(0, 2));
    for (int k = 0; k < junk; k++) begin pv[i] = 1; i++; end
    sof_i = i; cnt = 0; p = i; short_i = -1;
    while (cnt < n_pix && i < N - 40) begin
      if (i == sof_i || $urandom_range(0, 3) != 0) begin
        pv[i] = 1; sf[i] = (i == sof_i); ef[i] = 1; cnt++; p = i;
      end
      i++;
    end
    if (short_frame) begin
      short_i = p + 1 + int'($urandom_range(0, 2));
      pv[short_i] = 1; sf[short_i] = 1;
    end else begin
      first = 1;
      for (int k = p + 1; k < p + 21; k++) begin
        if ($urandom_range(0, 1) != 0) begin pv[k] = 1; sf[k] = first; first = 0; end
      end
    end
    t = int'($urandom_range(0, 3));
    for (int k = 0; k < n_words && t < N; k++) begin
      wv[t] = 1; t += int'($urandom_range(1, gap_max));
    end
    // Completion: short sof ends the frame at once; otherwise FLUSH (entered after the last
    // pixel) ends on the 12th word or after TMO consecutive word-free FLUSH cycles.
    wc = 0; w_full = -1; wl = -1; tmo = 0;
    for (int k = 0; k < N; k++)
      if (wv[k]) begin wc++; wl = k; if (wc == NWORD) w_full = k; end
    if (short_frame) stop = short_i;
    else if (w_full >= 0) stop = (p + 1 > w_full) ? p + 1 : w_full;
    else begin stop = ((p + 1 > wl + 1) ? p + 1 : wl + 1) + TMO - 1; tmo = 1; end
    wc = 0;
    for (int k = 0; k <= stop; k++) if (wv[k]) wc++;
    exp_err = short_frame || tmo || (wc > NWORD);
    exp_out = (wc > NWORD) ? NWORD : wc;
    exp_in  = n_pix;

    start = 1; cycle(); start = 0;
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
    end
    rst_len = 0;
    for (int k = 0; k < 20 && accel_rst === 1'b1; k++) begin rst_len++; cycle(); end
    tests++;
    if (rst_len != RST_C) begin
      fails++; $display("FAIL %s accel_rst_len: got %0d expected %0d", name, rst_len, RST_C);
    end

    done_iter = -1; pulses = 0;
    for (int k = 0; k <= stop + 4 && k < N; k++) begin
      cam_pixel_valid = pv[k]; cam_sof = sf[k]; accel_out_valid = wv[k];
      #1;
      tests++;
      if (accel_pixel_valid !== ef[k]) begin
        fails++;
        $display("FAIL %s fwd@%0d: got %b expected %b", name, k, accel_pixel_valid, ef[k]);
      end
      cycle();
      if (done === 1'b1) begin pulses++; if (done_iter < 0) done_iter = k; end
    end
    idle_inputs();
    tests++;
    if (done_iter != stop) begin
      fails++; $display("FAIL %s done_cycle: got %0d expected %0d", name, done_iter, stop);
    end
    tests++;
    if (pulses != 1) begin
      fails++; $display("FAIL %s done_pulses: got %0d expected 1", name, pulses);
    end
  endtask

  task automatic check_status(input string name, input bit ee, input int ei, input int eo);
    tests++;
    if (error !== ee) begin fails++; $display("FAIL %s error: got %b expected %b", name, error, ee); end
    tests++;
    if (in_pixel_cnt !== CNT_W'(ei)) begin
      fails++; $display("FAIL %s in_pixel_cnt: got %0d expected %0d", name, in_pixel_cnt, ei);
    end
    tests++;
    if (out_word_cnt !== CNT_W'(eo)) begin
      fails++; $display("FAIL %s out_word_cnt: got %0d expected %0d", name, out_word_cnt, eo);
    end
    tests++;
    if (busy !== 1'b0 || accel_rst !== 1'b1) begin
      fails++; $display("FAIL %s idle_outputs: busy=%b accel_rst=%b expected 0/1", name, busy, accel_rst);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs();
    #12;
    tests++;
    if (accel_rst !== 1 || busy !== 0 || done !== 0 || error !== 0 ||
        in_pixel_cnt !== '0 || out_word_cnt !== '0 || accel_pixel_valid !== 0) begin
      fails++;
      $display("FAIL reset_values: rst=%b busy=%b done=%b err=%b in=%0d out=%0d fwd=%b",
               accel_rst, busy, done, error, in_pixel_cnt, out_word_cnt, accel_pixel_valid);
    end
    @(negedge clk); rst_n = 1; cycle();
  endtask

  task automatic test_nominal();
    bit ee; int ei, eo;
    for (int r = 0; r < 3; r++) begin
      drive_frame("nominal", 0, NPIX, 0, NWORD, 8, ee, ei, eo);
      check_status("nominal", ee, ei, eo);
      tests++;
      if (ee !== 1'b0 || eo != NWORD) begin
        fails++; $display("FAIL nominal_plan: model err=%b words=%0d expected 0/12", ee, eo);
      end
    end
  endtask

  task automatic test_mid_stream();
    bit ee; int ei, eo;
    drive_frame("mid_stream", 5, NPIX, 0, NWORD, 8, ee, ei, eo);
    check_status("mid_stream", ee, ei, eo);
  endtask

  task automatic test_short_frame();
    bit ee; int ei, eo;
    drive_frame("short_frame", 0, 40, 1, 5, 8, ee, ei, eo);
    check_status("short_frame", ee, ei, eo);
  endtask

  task automatic test_flush_timeout();
    bit ee; int ei, eo;
    drive_frame("flush_timeout", 0, NPIX, 0, 10, 8, ee, ei, eo);
    check_status("flush_timeout", ee, ei, eo);
  endtask

  task automatic test_overflow();
    bit ee; int ei, eo;
    drive_frame("overflow", 0, NPIX, 0, NWORD + 1, 3, ee, ei, eo);
    check_status("overflow", ee, ei, eo);
  endtask

  task automatic test_abort();
    int dn;
    start = 1; cycle(); start = 0;
    repeat (RST_C) cycle();
    tests++;
    if (accel_rst !== 1'b0) begin fails++; $display("FAIL abort_arm: accel_rst got %b expected 0", accel_rst); end
    for (int k = 0; k < 20; k++) begin
      cam_pixel_valid = 1; cam_sof = (k == 0); accel_out_valid = (k < 3);
      #1;
      tests++;
      if (accel_pixel_valid !== 1'b1) begin
        fails++; $display("FAIL abort_fwd@%0d: got %b expected 1", k, accel_pixel_valid);
      end
      cycle();
    end
    idle_inputs(); abort = 1; cycle(); abort = 0;
    tests++;
    if (busy !== 0 || accel_rst !== 1 || done !== 0) begin
      fails++; $display("FAIL abort_idle: busy=%b rst=%b done=%b expected 0/1/0", busy, accel_rst, done);
    end
    check_status("abort", 1'b0, 20, 3);
    dn = 0;
    for (int k = 0; k < 5; k++) begin
      cam_pixel_valid = 1; cam_sof = $urandom_range(0, 1) != 0; accel_out_valid = 1;
      #1;
      tests++;
      if (accel_pixel_valid !== 1'b0) begin
        fails++; $display("FAIL abort_gate@%0d: got %b expected 0", k, accel_pixel_valid);
      end
      cycle();
      if (done === 1'b1) dn++;
    end
    idle_inputs();
    tests++;
    if (dn != 0) begin fails++; $display("FAIL abort_no_done: got %0d pulses expected 0", dn); end
    start = 1; abort = 1; cycle(); idle_inputs();
    tests++;
    if (busy !== 0 || accel_rst !== 1) begin
      fails++; $display("FAIL start_abort_idle: busy=%b rst=%b expected 0/1", busy, accel_rst);
    end
    check_status("start_abort", 1'b0, 20, 3);
  endtask

  task automatic test_reset_mid_flush();
    start = 1; cycle(); start = 0;
    repeat (RST_C) cycle();
    for (int k = 0; k < NPIX; k++) begin
      cam_pixel_valid = 1; cam_sof = (k == 0); accel_out_valid = (k < 2);
      cycle();
    end
    idle_inputs();
    repeat (3) cycle();
    tests++;
    if (busy !== 1 || in_pixel_cnt !== CNT_W'(NPIX) || out_word_cnt !== CNT_W'(2)) begin
      fails++;
      $display("FAIL pre_reset_flush: busy=%b in=%0d out=%0d expected 1/64/2", busy, in_pixel_cnt, out_word_cnt);
    end
    #2 rst_n = 0;
    #1;
    tests++;
    if (accel_rst !== 1 || busy !== 0 || done !== 0 || error !== 0 ||
        in_pixel_cnt !== '0 || out_word_cnt !== '0) begin
      fails++;
      $display("FAIL async_reset: rst=%b busy=%b done=%b err=%b in=%0d out=%0d",
               accel_rst, busy, done, error, in_pixel_cnt, out_word_cnt);
    end
    @(negedge clk); rst_n = 1; cycle();
    check_status("post_reset", 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mid_stream();
    test_short_frame();
    test_flush_timeout();
    test_abort();
    test_overflow();
    test_reset_mid_flush();
    test_nominal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
